// File: rtl/apb4_slave_mem_if.sv
// APB4 completer bus bundle.
// master modport: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB and receives PRDATA/PREADY/PSLVERR.
// slave modport : the mirror image, used by apb4_slave_mem.
interface apb4_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_slave_mem.sv
// APB4 completer backed by a word-addressed register array.
// Adds WAIT_STATES PREADY-low cycles per transfer, byte-strobed writes and PSLVERR for
// out-of-range or misaligned addresses.
// Ports:
//   PCLK    - clock, rising edge
//   PRESET  - synchronous active-high reset; clears state and the array
//   apb     - APB4 bus (slave modport of apb4_slave_mem_if)
//   ps      - current slave state: 0 IDLE, 1 SETUP (wait), 2 ACCESS
module apb4_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  apb4_slave_mem_if.slave        apb,
  output logic [1:0]             ps
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OB = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  state_e                r_state, w_state_d;
  logic [3:0]            r_cnt, w_cnt_d;
  logic                  r_write;
  logic                  r_err;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_strb;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_setup;
  logic w_addr_err;
  logic w_commit;

  assign w_setup    = apb.PSEL && !apb.PENABLE;
  // Out of range or not aligned to a word boundary; the mask term vanishes when NB == 1.
  assign w_addr_err = ((apb.PADDR >> OB) >= ADDR_WIDTH'(DEPTH)) ||
                      ((apb.PADDR & ADDR_WIDTH'(NB - 1)) != '0);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_commit  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_setup) begin
          w_cnt_d   = WS;
          w_state_d = (WS != 4'd0) ? StSetup : StAccess;
        end
      end
      StSetup: begin
        if (!apb.PSEL) begin
          // Master abandoned the transfer: drop it without writing.
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) w_state_d = StAccess;
        end
      end
      StAccess: begin
        w_state_d = StIdle;
        w_commit  = r_write && !r_err;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      // Only the setup-phase sample is used; later bus changes are ignored.
      if (r_state == StIdle && w_setup) begin
        r_write <= apb.PWRITE;
        r_err   <= w_addr_err;
        r_idx   <= apb.PADDR[OB +: IW];
        r_wdata <= apb.PWDATA;
        r_strb  <= apb.PSTRB;
      end
      if (w_commit) begin
        for (int b = 0; b < NB; b++) begin
          if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  assign apb.PREADY  = (r_state == StAccess);
  assign apb.PSLVERR = (r_state == StAccess) && r_err;
  assign apb.PRDATA  = (r_state == StAccess && !r_write && !r_err) ? r_mem[r_idx] : '0;
  assign ps          = r_state;

endmodule
